// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - frame-synchronous arbiter sharing the 4-digit display
// Changes the serializer's BCD word only on frame boundaries; a watchdog forces boundaries.
module display_arbiter #(
    parameter int          HOLD_FRAMES = 4,
    parameter int          TIMEOUT     = 4096,
    parameter logic [15:0] IDLE_CODE   = 16'hFFFF,
    parameter logic [15:0] ERR_CODE    = 16'hEEEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        entry_req,
    input  logic [15:0] entry_bcd,
    input  logic        result_req,
    input  logic [15:0] result_bcd,
    input  logic        err_req,
    input  logic        frame_done,
    output logic [15:0] bcd_out,
    output logic [1:0]  grant,
    output logic        switch_pulse,
    output logic        stall
);

    typedef enum logic [1:0] {
        G_NONE   = 2'd0,
        G_ENTRY  = 2'd1,
        G_RESULT = 2'd2,
        G_ERR    = 2'd3
    } grant_t;

    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  HOLD_MAX = 4'(HOLD_FRAMES);

    grant_t      state, next_state, cand;
    logic        fd_q;
    logic [15:0] wd_cnt;
    logic [3:0]  hold_cnt;
    logic        real_edge, synth_edge, boundary, do_switch, cur_req;
    logic [15:0] next_bcd;

    assign real_edge  = frame_done & ~fd_q;
    assign synth_edge = (wd_cnt == WD_LAST) & ~real_edge;
    assign boundary   = real_edge | synth_edge;
    assign do_switch  = boundary & (next_state != state);
    assign grant      = state;

    always_comb begin
        cand       = G_NONE;
        cur_req    = 1'b0;
        next_state = state;
        next_bcd   = IDLE_CODE;

        if (err_req)         cand = G_ERR;
        else if (result_req) cand = G_RESULT;
        else if (entry_req)  cand = G_ENTRY;

        case (state)
            G_ENTRY:  cur_req = entry_req;
            G_RESULT: cur_req = result_req;
            G_ERR:    cur_req = err_req;
            default:  cur_req = 1'b0;
        endcase

        // Enum encoding follows priority, so a numeric compare ranks sources.
        if (boundary) begin
            if (state == G_NONE || cand > state)
                next_state = cand;
            else if (!cur_req && hold_cnt >= HOLD_MAX)
                next_state = cand;
        end

        case (next_state)
            G_ENTRY:  next_bcd = entry_bcd;
            G_RESULT: next_bcd = result_bcd;
            G_ERR:    next_bcd = ERR_CODE;
            default:  next_bcd = IDLE_CODE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= G_NONE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fd_q         <= 1'b1;
            wd_cnt       <= 16'd0;
            stall        <= 1'b0;
            hold_cnt     <= 4'd0;
            bcd_out      <= IDLE_CODE;
            switch_pulse <= 1'b0;
        end else begin
            fd_q         <= frame_done;
            wd_cnt       <= boundary ? 16'd0 : wd_cnt + 16'd1;
            switch_pulse <= do_switch;
            if (real_edge)       stall <= 1'b0;
            else if (synth_edge) stall <= 1'b1;
            if (boundary) begin
                bcd_out <= next_bcd;
                if (do_switch)             hold_cnt <= 4'd1;
                else if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - directed self-checking bench for display_arbiter
module tb_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        entry_req, result_req, err_req, frame_done;
    logic [15:0] entry_bcd, result_bcd;
    logic [15:0] bcd_out;
    logic [1:0]  grant;
    logic        switch_pulse, stall;

    int total = 0;
    int bad   = 0;

    display_arbiter #(
        .HOLD_FRAMES(4),
        .TIMEOUT(16),
        .IDLE_CODE(16'hFFFF),
        .ERR_CODE(16'hEEEE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .entry_req(entry_req),
        .entry_bcd(entry_bcd),
        .result_req(result_req),
        .result_bcd(result_bcd),
        .err_req(err_req),
        .frame_done(frame_done),
        .bcd_out(bcd_out),
        .grant(grant),
        .switch_pulse(switch_pulse),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Low for one cycle then high: the rising-edge cycle's update is visible on return.
    task automatic fedge();
        frame_done = 1'b0;
        step();
        frame_done = 1'b1;
        step();
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; frame_done = 1'b0;
        entry_req = 1'b0; result_req = 1'b0; err_req = 1'b0;
        entry_bcd = 16'h0000; result_bcd = 16'h0000;
        step(); step();
        rst = 1'b0;
        check("rst_grant", 16'(grant), 16'd0);
        check("rst_bcd", bcd_out, 16'hFFFF);
        check("rst_pulse", 16'(switch_pulse), 16'd0);
        check("rst_stall", 16'(stall), 16'd0);

        // Entry granted on first edge, bus change mid-frame is not shown
        entry_req = 1'b1; entry_bcd = 16'h1234;
        fedge();
        check("entry_grant", 16'(grant), 16'd1);
        check("entry_bcd", bcd_out, 16'h1234);
        check("entry_pulse", 16'(switch_pulse), 16'd1);
        entry_bcd = 16'h5678;
        step();
        check("entry_pulse_off", 16'(switch_pulse), 16'd0);
        step();
        check("entry_bcd_stable", bcd_out, 16'h1234);

        // Result preempts entry only at the next edge
        result_req = 1'b1; result_bcd = 16'h0042;
        step();
        check("res_wait_grant", 16'(grant), 16'd1);
        fedge();
        check("res_grant", 16'(grant), 16'd2);
        check("res_bcd", bcd_out, 16'h0042);
        check("res_pulse", 16'(switch_pulse), 16'd1);

        // Result dropped: held through hold_cnt=4, dropped source's bus still refreshed
        result_req = 1'b0; result_bcd = 16'h0099;
        fedge();
        check("hold1_grant", 16'(grant), 16'd2);
        check("hold1_bcd", bcd_out, 16'h0099);
        check("hold1_pulse", 16'(switch_pulse), 16'd0);
        fedge();
        check("hold2_grant", 16'(grant), 16'd2);
        fedge();
        check("hold3_grant", 16'(grant), 16'd2);
        fedge();
        check("hold_exp_grant", 16'(grant), 16'd1);
        check("hold_exp_bcd", bcd_out, 16'h5678);
        check("hold_exp_pulse", 16'(switch_pulse), 16'd1);

        // Result back, then error pulse preempts at hold_cnt=1
        result_req = 1'b1; result_bcd = 16'h0042;
        fedge();
        check("res2_grant", 16'(grant), 16'd2);
        err_req = 1'b1;
        fedge();
        check("err_grant", 16'(grant), 16'd3);
        check("err_bcd", bcd_out, 16'hEEEE);
        check("err_pulse", 16'(switch_pulse), 16'd1);
        err_req = 1'b0;
        fedge();
        check("err_hold1", 16'(grant), 16'd3);
        check("err_hold1_bcd", bcd_out, 16'hEEEE);
        fedge();
        fedge();
        check("err_hold3", 16'(grant), 16'd3);
        fedge();
        check("err_release_grant", 16'(grant), 16'd2);
        check("err_release_bcd", bcd_out, 16'h0042);

        // Watchdog: synthetic boundary 16 cycles after the last one
        frame_done = 1'b0; result_bcd = 16'h0777;
        for (int i = 0; i < 15; i++) step();
        check("wd_before_stall", 16'(stall), 16'd0);
        check("wd_before_bcd", bcd_out, 16'h0042);
        step();
        check("wd_stall", 16'(stall), 16'd1);
        check("wd_bcd", bcd_out, 16'h0777);
        check("wd_grant", 16'(grant), 16'd2);
        fedge();
        check("wd_clear", 16'(stall), 16'd0);

        // Reset mid-frame with frame_done high through release
        rst = 1'b1;
        step();
        check("mid_rst_grant", 16'(grant), 16'd0);
        check("mid_rst_bcd", bcd_out, 16'hFFFF);
        rst = 1'b0;
        step(); step(); step();
        check("post_rst_grant", 16'(grant), 16'd0);
        check("post_rst_bcd", bcd_out, 16'hFFFF);
        fedge();
        check("post_rst_edge_grant", 16'(grant), 16'd2);
        check("post_rst_edge_bcd", bcd_out, 16'h0777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
